// File: rtl/reg_seq_pkg.sv
// Shared encodings for the 4-bit function register, its command sequencer and
// the CPU control unit. Optional shadow feature macro: REG_SEQ_SHADOW_EN.
package reg_seq_pkg;

  // Register func-pin encodings
  localparam logic [3:0] FUNC_HOLD  = 4'b0000;
  localparam logic [3:0] FUNC_LOAD  = 4'b0001;
  localparam logic [3:0] FUNC_CLEAR = 4'b0010;
  localparam logic [3:0] FUNC_SHR   = 4'b0011;
  localparam logic [3:0] FUNC_SHL   = 4'b0100;

  // Command opcodes on cmd_op (5..7 are illegal)
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_SHL   = 3'd4;

  // Sequencer FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // True for every opcode the sequencer knows how to execute
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SHL);
  endfunction

  // True for the two shift opcodes
  function automatic logic op_is_shift(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

  // Map a command opcode to the register func encoding (Hold for NOP/illegal)
  function automatic logic [3:0] op_to_func(input logic [2:0] op);
    logic [3:0] f;
    case (op)
      OP_LOAD:  f = FUNC_LOAD;
      OP_CLEAR: f = FUNC_CLEAR;
      OP_SHR:   f = FUNC_SHR;
      OP_SHL:   f = FUNC_SHL;
      default:  f = FUNC_HOLD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/reg_seq_shadow.sv
// Shadow copy of the 4-bit function register: follows the same func/in pins
// the real register sees, edge for edge. Built only with REG_SEQ_SHADOW_EN.
`ifdef REG_SEQ_SHADOW_EN
module reg_seq_shadow
  import reg_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned FUNC_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FUNC_W-1:0] i_func,
  input  logic [DATA_W-1:0] i_in,
  output logic [DATA_W-1:0] o_q,
  output logic [DATA_W-1:0] o_next
);

  logic [DATA_W-1:0] r_q;

  // Value the register will take at the next edge given the current func/in
  always_comb begin
    o_next = r_q;
    case (i_func)
      FUNC_W'(FUNC_LOAD):  o_next = i_in;
      FUNC_W'(FUNC_CLEAR): o_next = '0;
      FUNC_W'(FUNC_SHR):   o_next = r_q >> 1;
      FUNC_W'(FUNC_SHL):   o_next = r_q << 1;
      default:             o_next = r_q;
    endcase
  end

  // Shadow register state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= o_next;
    end
  end

  assign o_q = r_q;

endmodule
`endif

// File: rtl/reg_func_sequencer.sv
// Command-driven controller for the 4-bit function register. Accepts one op
// per valid/ready handshake, expands shifts into N single-bit shift cycles on
// reg_func, and pulses done (qualified by err) at completion.
// Optional feature macro: REG_SEQ_SHADOW_EN adds shadow_q and shift early exit.
module reg_func_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned FUNC_W = 4,
  parameter int unsigned AMT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [AMT_W-1:0]  cmd_amt,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [FUNC_W-1:0] reg_func,
  output logic [DATA_W-1:0] reg_in,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef REG_SEQ_SHADOW_EN
  ,
  output logic [DATA_W-1:0] shadow_q
`endif
);

  // Largest shift count: DATA_W, unless cmd_amt cannot even express it
  localparam int unsigned     AMT_MAX   = (1 << AMT_W) - 1;
  localparam logic [AMT_W-1:0] AMT_CLAMP = (DATA_W > AMT_MAX) ? AMT_W'(AMT_MAX)
                                                              : AMT_W'(DATA_W);
  localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);

  state_t            r_state;
  logic [AMT_W-1:0]  r_cnt;
  logic [FUNC_W-1:0] r_func;
  logic [DATA_W-1:0] r_in;
  logic              r_done;
  logic              r_err;

  logic              w_hs;
  logic [AMT_W-1:0]  w_n;
  logic              w_illegal;
  logic [FUNC_W-1:0] w_func;
  logic              w_last;

  assign cmd_ready = (r_state == IDLE) & ~reset;
  assign busy      = (r_state == EXEC);
  assign w_hs      = cmd_valid & cmd_ready;

  // Decode the offered command into its effective cycle count and func code
  always_comb begin
    w_n       = '0;
    w_illegal = ~op_is_legal(cmd_op);
    w_func    = FUNC_W'(op_to_func(cmd_op));
    case (cmd_op)
      OP_LOAD, OP_CLEAR: w_n = AMT_ONE;
      OP_SHR, OP_SHL:    w_n = (cmd_amt > AMT_CLAMP) ? AMT_CLAMP : cmd_amt;
      default:           w_n = '0;
    endcase
  end

`ifdef REG_SEQ_SHADOW_EN
  logic [DATA_W-1:0] w_shadow_next;

  reg_seq_shadow #(
    .DATA_W (DATA_W),
    .FUNC_W (FUNC_W)
  ) u_shadow (
    .clock  (clock),
    .reset  (reset),
    .i_func (r_func),
    .i_in   (r_in),
    .o_q    (shadow_q),
    .o_next (w_shadow_next)
  );

  // A shift also ends on the edge that empties the register; further shifts
  // of zero would be no-ops anyway.
  assign w_last = (r_cnt == AMT_ONE)
                | (((r_func == FUNC_W'(FUNC_SHR)) | (r_func == FUNC_W'(FUNC_SHL)))
                   & (w_shadow_next == '0));
`else
  assign w_last = (r_cnt == AMT_ONE);
`endif

  // FSM, down-counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_func  <= FUNC_W'(FUNC_HOLD);
      r_in    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == IDLE) begin
        if (w_hs) begin
          if (w_n != '0) begin
            r_state <= EXEC;
            r_cnt   <= w_n;
            r_func  <= w_func;
            r_in    <= cmd_data;
          end else begin
            r_done <= 1'b1;
            r_err  <= w_illegal;
          end
        end
      end else begin
        if (w_last) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_func  <= FUNC_W'(FUNC_HOLD);
          r_done  <= 1'b1;
        end else begin
          r_cnt <= r_cnt - AMT_ONE;
        end
      end
    end
  end

  assign reg_func = r_func;
  assign reg_in   = r_in;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_reg_func_sequencer.sv
// Directed self-checking bench for reg_func_sequencer, including a behavioural
// model of the function register driven by the sequencer's func/in outputs.
module tb_reg_func_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] cmd_amt = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] reg_func;
  logic [3:0] reg_in;
  logic       busy;
  logic       done;
  logic       err;
`ifdef REG_SEQ_SHADOW_EN
  logic [3:0] shadow_q;
`endif

  int checks = 0;
  int errors = 0;
  int hold_viol = 0;
  logic mon_en = 1'b0;
  logic [3:0] tb_reg = 4'b0000;

  reg_func_sequencer #(
    .DATA_W (4),
    .FUNC_W (4),
    .AMT_W  (3)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .reg_func  (reg_func),
    .reg_in    (reg_in),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef REG_SEQ_SHADOW_EN
    ,
    .shadow_q  (shadow_q)
`endif
  );

  always #5 clk = ~clk;

  // Function register model fed by the sequencer outputs
  always @(posedge clk) begin
    case (reg_func)
      4'b0001: tb_reg <= reg_in;
      4'b0010: tb_reg <= 4'b0000;
      4'b0011: tb_reg <= tb_reg >> 1;
      4'b0100: tb_reg <= tb_reg << 1;
      default: tb_reg <= tb_reg;
    endcase
  end

  // Non-Hold func while not busy must never happen
  always @(negedge clk) begin
    if (mon_en && (reg_func !== 4'b0000) && (busy !== 1'b1)) hold_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command for a single edge; sequencer must be ready
  task automatic send(input string tag, input logic [2:0] op, input logic [2:0] amt,
                      input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Follow an accepted command to its done pulse (bounded), then one more cycle
  task automatic run_op(input string tag, input logic [3:0] f, input int n_exp,
                        input logic e_exp);
    int   cnt = 0;
    int   dn  = 0;
    logic e   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1 && reg_func === f) cnt++;
      if (done === 1'b1) begin
        dn++;
        e = err;
        break;
      end
      tick();
    end
    chk({tag, ".cycles"}, 32'(cnt), 32'(n_exp));
    chk({tag, ".done"}, 32'(dn), 32'd1);
    chk({tag, ".err"}, 32'(e), 32'(e_exp));
    chk({tag, ".func_after"}, 32'(reg_func), 32'd0);
    tick();
    chk({tag, ".done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;

    // Reset state
    reset = 1'b1;
    tick(); tick(); tick();
    chk("rst.func",  32'(reg_func),  32'd0);
    chk("rst.in",    32'(reg_in),    32'd0);
    chk("rst.done",  32'(done),      32'd0);
    chk("rst.err",   32'(err),       32'd0);
    chk("rst.busy",  32'(busy),      32'd0);
    chk("rst.ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 32'(cmd_ready), 32'd1);
    mon_en = 1'b1;

    // 1. Reset during SHL amt=5 aborts with no done
    send("abort", 3'd4, 3'd5, 4'b0000);
    chk("abort.busy", 32'(busy), 32'd1);
    chk("abort.func", 32'(reg_func), 32'h4);
    tick();
    chk("abort.func2", 32'(reg_func), 32'h4);
    reset = 1'b1;
    tick();
    chk("abort.func_hold", 32'(reg_func), 32'd0);
    chk("abort.busy_off",  32'(busy), 32'd0);
    chk("abort.no_done",   32'(done), 32'd0);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    chk("abort.never_done", 32'(dn), 32'd0);

    // 2. LOAD 1011 then SHR 2 -> register 0010
    send("load", 3'd1, 3'd0, 4'b1011);
    chk("load.reg_in", 32'(reg_in), 32'hB);
    run_op("load", 4'b0001, 1, 1'b0);
    chk("load.reg", 32'(tb_reg), 32'hB);
    send("shr2", 3'd3, 3'd2, 4'b0110);
    chk("shr2.reg_in", 32'(reg_in), 32'h6);
    run_op("shr2", 4'b0011, 2, 1'b0);
    chk("shr2.reg", 32'(tb_reg), 32'h2);

    // 3. SHL amt=7 clamps to 4 cycles
    send("shl7", 3'd4, 3'd7, 4'b0000);
    run_op("shl7", 4'b0100, 4, 1'b0);
    chk("shl7.reg", 32'(tb_reg), 32'h0);

    // 4. Zero-count and illegal ops
    send("shr0", 3'd3, 3'd0, 4'b0000);
    chk("shr0.func", 32'(reg_func), 32'd0);
    run_op("shr0", 4'b0011, 0, 1'b0);
    send("nop", 3'd0, 3'd3, 4'b0000);
    run_op("nop", 4'b0000, 0, 1'b0);
    send("ill6", 3'd6, 3'd2, 4'b0000);
    run_op("ill6", 4'b0000, 0, 1'b1);
    send("ill7", 3'd7, 3'd0, 4'b0000);
    run_op("ill7", 4'b0000, 0, 1'b1);

    // 5. Back-to-back: CLEAR then SHL 1 with cmd_valid held high
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_amt   = 3'd0;
    cmd_data  = 4'b0000;
    chk("b2b.ready0", 32'(cmd_ready), 32'd1);
    tick();
    cmd_op  = 3'd4;
    cmd_amt = 3'd1;
    chk("b2b.clr_func",  32'(reg_func),  32'h2);
    chk("b2b.clr_busy",  32'(busy),      32'd1);
    chk("b2b.not_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("b2b.done1",  32'(done),      32'd1);
    chk("b2b.ready1", 32'(cmd_ready), 32'd1);
    chk("b2b.hold1",  32'(reg_func),  32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b.shl_func", 32'(reg_func), 32'h4);
    chk("b2b.shl_busy", 32'(busy),     32'd1);
    chk("b2b.no_done",  32'(done),     32'd0);
    tick();
    chk("b2b.done2", 32'(done),     32'd1);
    chk("b2b.hold2", 32'(reg_func), 32'd0);
    chk("b2b.idle2", 32'(busy),     32'd0);
    tick();

`ifdef REG_SEQ_SHADOW_EN
    // 6. Early exit when the shadow copy empties
    send("sh_load", 3'd1, 3'd0, 4'b0100);
    run_op("sh_load", 4'b0001, 1, 1'b0);
    chk("sh_load.shadow", 32'(shadow_q), 32'h4);
    send("sh_shr7", 3'd3, 3'd7, 4'b0000);
    run_op("sh_shr7", 4'b0011, 3, 1'b0);
    chk("sh_shr7.shadow", 32'(shadow_q), 32'h0);
    chk("sh_shr7.reg",    32'(tb_reg),   32'h0);
`endif

    chk("hold_while_idle", 32'(hold_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
